branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Branch prediction and misprediction-recovery controller for the 5-stage pipeline.
//  Gives IF a taken/target prediction from a direct-mapped BTB with 2-bit counters.
//  Checks the EX-stage branch decision against the prediction carried down the pipe.
//  On mispredict, sequences PC redirect and IF/ID + ID/EX flush; keeps branch/mispredict stats.
// PARAMETERS
//  PC_W     32  program-counter width
//  ENTRIES  16  BTB/BHT entries, power of 2, >=2
//  IDX_W    4   log2(ENTRIES), index = pc[IDX_W+1:2]
//  STAT_W   16  width of saturating statistics counters
// PORTS
//  clk              in   1       clock, rising edge
//  rst_n            in   1       asynchronous, active-low reset
//  if_pc            in   PC_W    fetch PC for lookup
//  pred_taken       out  1       combinational: BTB hit && ctr[1]
//  pred_target      out  PC_W    combinational: hit entry target, else if_pc+4
//  ex_valid         in   1       EX holds a real instruction
//  ex_is_branch     in   1       EX instr is conditional branch (opcode 11000, Branch=1)
//  ex_decision      in   1       resolved taken flag from branch decision unit
//  ex_pc            in   PC_W    PC of EX instruction
//  ex_target        in   PC_W    computed branch target
//  ex_pred_taken    in   1       prediction made for this instr at IF
//  ex_pred_target   in   PC_W    target predicted at IF
//  stall            in   1       pipeline frozen; EX re-presented next cycle
//  redirect         out  1       registered 1-cycle pulse: load redirect_pc into PC
//  redirect_pc      out  PC_W    registered correct next PC
//  flush_if_id      out  1       registered, same cycle as redirect
//  flush_id_ex      out  1       registered, same cycle as redirect
//  branch_cnt       out  STAT_W  resolved branches, saturating
//  mispred_cnt      out  STAT_W  mispredictions, saturating
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; redirect/flush=0; redirect_pc=0; stats=0;
//   all entries valid=0, ctr=2'b01 (weakly not-taken). Deassertion applies on a clock edge.
//  resolve = ex_valid & ex_is_branch & ~stall & (state==IDLE).
//  mispredict = resolve & ((ex_decision != ex_pred_taken) |
//   (ex_decision & ex_pred_taken & ex_target != ex_pred_target)).
//  FSM, two states:
//   IDLE: mispredict in cycle N -> REDIRECT at N+1; redirect=flush_*=1 at N+1;
//    redirect_pc = ex_decision ? ex_target : ex_pc+4 (wraps mod 2^PC_W).
//   REDIRECT: lasts one cycle, then IDLE; outputs drop to 0; EX inputs ignored (wrong path);
//    no table update or stat count. stall has no effect in REDIRECT.
//  Table update at resolve (cycle N edge), entry idx=ex_pc[IDX_W+1:2]:
//   ctr: taken -> min(ctr+1,3), not-taken -> max(ctr-1,0); counts from 2'b01 on tag miss/invalid.
//   taken: valid=1, tag=ex_pc[PC_W-1:IDX_W+2], target=ex_target.
//   not-taken on miss: entry unchanged.
//  Lookup hit = valid & tag match. Same-cycle read/write to one index returns the OLD contents.
//  Stats: branch_cnt++ per resolve, mispred_cnt++ per mispredict; both saturate at all-ones.
//  Back-to-back: no new redirect can issue in the cycle after a redirect.
//  stall=1 in IDLE: no update, no redirect, no count.
// STRUCTURE
//  Shared package branch_pkg: FSM state encodings (S_IDLE, S_REDIRECT),
//   CTR_RESET=2'b01, CTR_MAX=2'b11, index/tag slice helpers.
//  Sub-module btb_table: storage arrays, async-reset valid/ctr, 1 comb read port, 1 write port.
//  Top: mispredict compare, FSM, registered redirect/flush outputs, stat counters.
// TESTING
//  1 Reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104; stats=0.
//  2 Branch at 0x100 taken to 0x80, ex_pred_taken=0 -> next cycle redirect=1,
//    redirect_pc=0x80, flushes=1; following cycle all 0; mispred_cnt=1; lookup 0x100 hits, target 0x80.
//  3 Same branch resolved taken 3 more times -> ctr=11; then not-taken with pred 1
//    -> redirect_pc=0x104; ctr=10, still predicts taken.
//  4 Mispredict, then EX holds another mispredicting branch in the REDIRECT cycle
//    -> ignored: one pulse only; branch_cnt +1.
//  5 Taken branch with ex_pred_taken=1 but ex_pred_target=0x90, ex_target=0x80 -> redirect to 0x80.
//  6 stall=1 with mispredicting branch -> no redirect; rst_n low during REDIRECT
//    -> outputs 0 at once; table invalid.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants and helpers for branch prediction/resolve
package branch_pkg;

  // Resolve FSM encodings
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  // 2-bit saturating counter values
  localparam logic [1:0] CTR_MIN   = 2'b00;
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_MAX   = 2'b11;

  // Word-aligned PCs: the table index starts above the byte offset
  localparam int unsigned IDX_LSB = 2;

  // Tag field begins just above the index field
  function automatic int unsigned tag_lsb(input int unsigned idx_w);
    return idx_w + IDX_LSB;
  endfunction

  // Saturating counter step toward taken or not-taken
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped BTB with 2-bit counters, 1 read / 1 write port
module btb_table
  import branch_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_taken,
  output logic [PC_W-1:0]  rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [PC_W-1:0]  wr_target
);

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];

  logic       wr_hit;
  logic [1:0] wr_ctr_d;

  // Read port sees registered contents, so a same-cycle write returns old data
  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_taken  = rd_hit && ctr_q[rd_idx][1];
    rd_target = target_q[rd_idx];
  end

  // New counter value; a miss or invalid entry restarts from weakly not-taken
  always_comb begin
    wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_ctr_d = ctr_next(wr_hit ? ctr_q[wr_idx] : CTR_RESET, wr_taken);
  end

  // Valid and counter state; a not-taken miss leaves the entry alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en && (wr_taken || wr_hit)) begin
      valid_q[wr_idx] <= 1'b1;
      ctr_q[wr_idx]   <= wr_ctr_d;
    end
  end

  // Tag and target are (re)allocated only by taken branches
  always_ff @(posedge clk) begin
    if (wr_en && wr_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch prediction lookup and mispredict redirect/flush control
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic              ex_decision,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [PC_W-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_target,
  input  logic              stall,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int TAG_LSB = int'(tag_lsb(IDX_W));
  localparam int TAG_W   = PC_W - TAG_LSB;

  logic [0:0]        state_q, state_d;
  logic              redirect_q, redirect_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic              resolve, mispredict;
  logic              rd_hit, rd_taken;
  logic [PC_W-1:0]   rd_target;

  btb_table #(
    .PC_W    (PC_W),
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[TAG_LSB-1:IDX_LSB]),
    .rd_tag    (if_pc[PC_W-1:TAG_LSB]),
    .rd_hit    (rd_hit),
    .rd_taken  (rd_taken),
    .rd_target (rd_target),
    .wr_en     (resolve),
    .wr_idx    (ex_pc[TAG_LSB-1:IDX_LSB]),
    .wr_tag    (ex_pc[PC_W-1:TAG_LSB]),
    .wr_taken  (ex_decision),
    .wr_target (ex_target)
  );

  // Fetch-side prediction: fall through to the next word on a miss
  always_comb begin
    pred_taken  = rd_taken;
    pred_target = rd_hit ? rd_target : if_pc + PC_W'(4);
  end

  // Resolve qualification, mispredict detect and next-state for FSM/outputs/stats
  always_comb begin
    resolve    = ex_valid && ex_is_branch && !stall && (state_q == S_IDLE);
    mispredict = resolve && ((ex_decision != ex_pred_taken) ||
                 (ex_decision && ex_pred_taken && (ex_target != ex_pred_target)));
    state_d       = mispredict ? S_REDIRECT : S_IDLE;
    redirect_d    = mispredict;
    redirect_pc_d = '0;
    if (mispredict) redirect_pc_d = ex_decision ? ex_target : ex_pc + PC_W'(4);
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && branch_cnt_q != '1)     branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mispredict && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  // Registered control state; redirect and both flushes share one pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush_if_id = redirect_q;
  assign flush_id_ex = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_decision, ex_pred_taken, stall;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_decision    (ex_decision),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_br(input logic [31:0] pc, input logic dec, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptg);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_decision = dec;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  // Present one branch for a single cycle, then sample registered results
  task automatic resolve_br(input logic [31:0] pc, input logic dec, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptg);
    set_br(pc, dec, tgt, ptk, ptg);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tg);
    if_pc = pc; #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    check({tag, ".target"}, pred_target, exp_tg);
  endtask

  task automatic check_pulse(input string tag, input logic exp_r, input logic [31:0] exp_pc);
    check({tag, ".redirect"}, {31'd0, redirect}, {31'd0, exp_r});
    check({tag, ".flush_if_id"}, {31'd0, flush_if_id}, {31'd0, exp_r});
    check({tag, ".flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, exp_r});
    if (exp_r) check({tag, ".redirect_pc"}, redirect_pc, exp_pc);
  endtask

  task automatic check_stats(input string tag, input int b, input int m);
    check({tag, ".branch_cnt"}, {16'd0, branch_cnt}, b);
    check({tag, ".mispred_cnt"}, {16'd0, mispred_cnt}, m);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h100; stall = 1'b0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_decision = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; ex_pred_target = '0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    lookup("rst.lookup", 32'h100, 1'b0, 32'h104);
    check_stats("rst", 0, 0);
    check_pulse("rst", 1'b0, 32'h0);
    check("rst.redirect_pc", redirect_pc, 32'h0);
    rst_n = 1'b1;
    idle_cycle();

    // 2: taken branch predicted not-taken
    resolve_br(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    check_pulse("t2", 1'b1, 32'h80);
    check_stats("t2", 1, 1);
    lookup("t2.lookup", 32'h100, 1'b1, 32'h80);
    idle_cycle();
    check_pulse("t2.drop", 1'b0, 32'h0);

    // 3: three correct taken, then two not-taken mispredicts walk 11->10->01
    for (int i = 0; i < 3; i++) begin
      resolve_br(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      check_pulse("t3.ok", 1'b0, 32'h0);
    end
    check_stats("t3.ok", 4, 1);
    resolve_br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    check_pulse("t3.nt", 1'b1, 32'h104);
    check_stats("t3.nt", 5, 2);
    lookup("t3.ctr10", 32'h100, 1'b1, 32'h80);
    idle_cycle();
    resolve_br(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    check_pulse("t3.nt2", 1'b1, 32'h104);
    lookup("t3.ctr01", 32'h100, 1'b0, 32'h80);
    idle_cycle();
    check_stats("t3.nt2", 6, 3);

    // 4: second mispredict presented during REDIRECT is ignored
    set_br(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    @(posedge clk); #1;
    check_pulse("t4.first", 1'b1, 32'h300);
    set_br(32'h240, 1'b1, 32'h400, 1'b0, 32'h244);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check_pulse("t4.ignored", 1'b0, 32'h0);
    check_stats("t4", 7, 4);
    lookup("t4.alias_evict", 32'h100, 1'b0, 32'h104);
    lookup("t4.new_entry", 32'h200, 1'b1, 32'h300);
    lookup("t4.no_alloc", 32'h240, 1'b0, 32'h244);

    // 5: direction right, target wrong
    resolve_br(32'h300, 1'b1, 32'h80, 1'b1, 32'h90);
    check_pulse("t5", 1'b1, 32'h80);
    check_stats("t5", 8, 5);
    idle_cycle();

    // Fall-through redirect wraps at the top of the address space
    resolve_br(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    check_pulse("wrap", 1'b1, 32'h0);
    check_stats("wrap", 9, 6);
    idle_cycle();

    // 6a: stall suppresses resolve entirely
    stall = 1'b1;
    resolve_br(32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    stall = 1'b0;
    check_pulse("t6.stall", 1'b0, 32'h0);
    check_stats("t6.stall", 9, 6);
    lookup("t6.stall_noupd", 32'h404, 1'b0, 32'h408);
    idle_cycle();

    // 6b: asynchronous reset in the REDIRECT cycle
    resolve_br(32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
    check_pulse("t6.pre", 1'b1, 32'h600);
    #2 rst_n = 1'b0;
    #1;
    check_pulse("t6.rst", 1'b0, 32'h0);
    check("t6.rst.redirect_pc", redirect_pc, 32'h0);
    check_stats("t6.rst", 0, 0);
    lookup("t6.rst.inval", 32'h500, 1'b0, 32'h504);
    lookup("t6.rst.inval2", 32'h200, 1'b0, 32'h204);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();

    // After reset a fresh mispredict works normally
    resolve_br(32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
    check_pulse("post", 1'b1, 32'h600);
    check_stats("post", 1, 1);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
